// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SEG-bit CLA slice per stage,
// carry and group P/G registered between stages, valid/ready on both sides.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             C_out,
  output logic             ovf,
  output logic             P_all,
  output logic             G_all
);

  localparam int unsigned NS = WIDTH / SEG;
  localparam int unsigned NG = SEG / 4;

  typedef struct packed {
    logic [SEG-1:0] sum;
    logic           cout;
    logic           c_msb;
    logic           p;
    logic           g;
  } slice_t;

  // a/b hold only the not-yet-added operand bits, shifted down so the next
  // slice always reads bits [SEG-1:0].
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry;
    logic             p;
    logic             g;
    logic             c_msb;
  } stage_t;

  // Carries into each bit of a 4-bit CLA unit.
  function automatic logic [3:0] cla4_carries(input logic [3:0] p,
                                              input logic [3:0] g,
                                              input logic       cin);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  function automatic logic group_gen(input logic [3:0] p, input logic [3:0] g);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Flat sum-of-products lookahead across the 4-bit groups of one slice.
  function automatic logic [NG:0] lookahead(input logic [NG-1:0] gp,
                                            input logic [NG-1:0] gg,
                                            input logic          cin);
    logic [NG:0] c;
    logic        acc;
    logic        term;
    for (int unsigned j = 0; j <= NG; j++) begin
      acc = cin;
      for (int unsigned m = 0; m < j; m++) acc = acc & gp[m];
      for (int unsigned i = 0; i < j; i++) begin
        term = gg[i];
        for (int unsigned m = i + 1; m < j; m++) term = term & gp[m];
        acc = acc | term;
      end
      c[j] = acc;
    end
    return c;
  endfunction

  function automatic logic block_gen(input logic [NG-1:0] gp, input logic [NG-1:0] gg);
    logic acc;
    logic term;
    acc = 1'b0;
    for (int unsigned i = 0; i < NG; i++) begin
      term = gg[i];
      for (int unsigned m = i + 1; m < NG; m++) term = term & gp[m];
      acc = acc | term;
    end
    return acc;
  endfunction

  function automatic slice_t cla_slice(input logic [SEG-1:0] a,
                                       input logic [SEG-1:0] b,
                                       input logic           cin);
    slice_t        r;
    logic [SEG-1:0] p;
    logic [SEG-1:0] g;
    logic [SEG-1:0] c;
    logic [NG-1:0]  gp;
    logic [NG-1:0]  gg;
    logic [NG:0]    gc;
    p = a ^ b;
    g = a & b;
    for (int unsigned j = 0; j < NG; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = group_gen(p[4*j +: 4], g[4*j +: 4]);
    end
    gc = lookahead(gp, gg, cin);
    for (int unsigned j = 0; j < NG; j++) begin
      c[4*j +: 4] = cla4_carries(p[4*j +: 4], g[4*j +: 4], gc[j]);
    end
    r.sum   = p ^ c;
    r.cout  = gc[NG];
    r.c_msb = c[SEG-1];
    r.p     = &gp;
    r.g     = block_gen(gp, gg);
    return r;
  endfunction

  stage_t st  [NS];
  stage_t nxt [NS];
  logic   stall;

  assign stall    = st[NS-1].valid & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    slice_t           r;
    logic [WIDTH-1:0] b_eff;
    logic             cin;
    b_eff = sub ? ~B : B;
    cin   = sub | C0;
    r     = cla_slice(A[SEG-1:0], b_eff[SEG-1:0], cin);

    nxt[0].valid          = in_valid;
    nxt[0].sum            = '0;
    nxt[0].sum[SEG-1:0]   = r.sum;
    nxt[0].a              = A >> SEG;
    nxt[0].b              = b_eff >> SEG;
    nxt[0].carry          = r.cout;
    nxt[0].p              = r.p;
    nxt[0].g              = r.g;
    nxt[0].c_msb          = r.c_msb;

    for (int unsigned k = 1; k < NS; k++) begin
      r = cla_slice(st[k-1].a[SEG-1:0], st[k-1].b[SEG-1:0], st[k-1].carry);
      nxt[k]                  = st[k-1];
      nxt[k].sum[k*SEG +: SEG] = r.sum;
      nxt[k].a                = st[k-1].a >> SEG;
      nxt[k].b                = st[k-1].b >> SEG;
      nxt[k].carry            = r.cout;
      nxt[k].p                = r.p & st[k-1].p;
      nxt[k].g                = r.g | (r.p & st[k-1].g);
      nxt[k].c_msb            = r.c_msb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NS; k++) st[k] <= '0;
    end else if (!stall) begin
      for (int unsigned k = 0; k < NS; k++) st[k] <= nxt[k];
    end
  end

  assign out_valid = st[NS-1].valid;
  assign sum       = st[NS-1].sum;
  assign C_out     = st[NS-1].carry;
  assign ovf       = st[NS-1].c_msb ^ st[NS-1].carry;
  assign P_all     = st[NS-1].p;
  assign G_all     = st[NS-1].g;

endmodule
